// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
package chan_err_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    ERR_OFF      = 2'd0,
    ERR_RANDOM   = 2'd1,
    ERR_BURST    = 2'd2,
    ERR_PERIODIC = 2'd3
  } err_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } err_state_e;

  // Low-bit mask of width rate; rates of 16 and above select all LFSR bits.
  function automatic logic [LFSR_W-1:0] rate_mask(input logic [4:0] rate);
    return (LFSR_W'(1) << rate) - LFSR_W'(1);
  endfunction

endpackage

// File: rtl/err_lfsr.sv
// Enable-gated 16-bit Galois LFSR with a reset seed.
module err_lfsr
  import chan_err_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= SEED;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_POLY : '0);
    end
  end

endmodule

// File: rtl/chan_err_injector.sv
// Channel impairment: flips masked bits of valid symbols in off/random/burst/periodic modes.
// Statistics counters are built only when CHAN_ERR_INJ_STATS_EN is defined.
module chan_err_injector
  import chan_err_pkg::*;
#(
  parameter int unsigned       W         = 2,
  parameter int unsigned       MAX_BURST = 8,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  localparam int unsigned      BL_W      = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode,
  input  logic [4:0]       cfg_rate,
  input  logic [BL_W-1:0]  cfg_burst_len,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [W-1:0]     cfg_bit_mask,
  input  logic             valid_i,
  input  logic [W-1:0]     sym_i,
  output logic             valid_o,
  output logic [W-1:0]     sym_o,
  output logic [W-1:0]     clean_o,
  output logic [W-1:0]     err_o,
  output logic             burst_active_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] err_bit_ct_o
);

  err_mode_e          mode_c;
  err_mode_e          mode_q;
  err_state_e         state_q;
  err_state_e         state_d;
  logic [BL_W-1:0]    rem_q;
  logic [BL_W-1:0]    rem_d;
  logic [CNT_W-1:0]   pcnt_q;
  logic [CNT_W-1:0]   pcnt_d;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  rmask;
  logic [BL_W-1:0]    len_c;
  logic [BL_W-1:0]    eff_len;
  logic               trig;
  logic               per_hit;
  logic               corrupt;
  logic [W-1:0]       err_c;

  err_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (valid_i),
    .value (lfsr)
  );

  // Trigger, burst length and period counter next value.
  always_comb begin
    mode_c  = err_mode_e'(cfg_mode);
    rmask   = rate_mask(cfg_rate);
    len_c   = cfg_burst_len;
    trig    = 1'b0;
    pcnt_d  = pcnt_q;
    per_hit = (cfg_period != '0) && (pcnt_q == cfg_period - CNT_W'(1));
    if (cfg_burst_len == '0) begin
      len_c = BL_W'(1);
    end else if (cfg_burst_len > BL_W'(MAX_BURST)) begin
      len_c = BL_W'(MAX_BURST);
    end
    eff_len = (mode_c == ERR_RANDOM) ? BL_W'(1) : len_c;
    case (mode_c)
      ERR_RANDOM, ERR_BURST: trig = ((lfsr & rmask) == rmask);
      ERR_PERIODIC:          trig = per_hit;
      default:               trig = 1'b0;
    endcase
    if (mode_c != ERR_PERIODIC) begin
      pcnt_d = '0;
    end else if (valid_i) begin
      // A shrunken period wraps the counter instead of letting it run away.
      if (cfg_period == '0 || pcnt_q >= cfg_period - CNT_W'(1)) pcnt_d = '0;
      else pcnt_d = pcnt_q + CNT_W'(1);
    end
  end

  // Burst FSM next state; a mode change aborts a burst and the symbol follows the new mode.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    corrupt = 1'b0;
    if (state_q == ST_BURST && (mode_c != mode_q || mode_c == ERR_OFF)) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      corrupt = valid_i && trig;
    end else if (state_q == ST_BURST) begin
      if (valid_i) begin
        corrupt = 1'b1;
        if (rem_q <= BL_W'(1)) begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - BL_W'(1);
        end
      end
    end else if (valid_i && trig) begin
      corrupt = 1'b1;
      if (eff_len > BL_W'(1)) begin
        state_d = ST_BURST;
        rem_d   = eff_len - BL_W'(1);
      end
    end
    err_c = corrupt ? cfg_bit_mask : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      mode_q         <= ERR_OFF;
      rem_q          <= '0;
      pcnt_q         <= '0;
      valid_o        <= 1'b0;
      sym_o          <= '0;
      clean_o        <= '0;
      err_o          <= '0;
      burst_active_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_c;
      rem_q          <= rem_d;
      pcnt_q         <= pcnt_d;
      valid_o        <= valid_i;
      sym_o          <= sym_i ^ err_c;
      clean_o        <= sym_i;
      err_o          <= err_c;
      burst_active_o <= (state_d == ST_BURST);
    end
  end

`ifdef CHAN_ERR_INJ_STATS_EN
  localparam int unsigned PW  = $clog2(W + 1);
  localparam int unsigned CW1 = CNT_W + 1;

  logic [PW-1:0]  pop;
  logic [CNT_W:0] err_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + PW'(err_c[i]);
    err_sum = {1'b0, err_bit_ct_o} + CW1'(pop);
  end

  // Saturating statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_ct_o     <= '0;
      err_bit_ct_o <= '0;
    end else if (valid_i) begin
      if (!(&sym_ct_o)) sym_ct_o <= sym_ct_o + CNT_W'(1);
      err_bit_ct_o <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
  end
`else
  assign sym_ct_o     = '0;
  assign err_bit_ct_o = '0;
`endif

endmodule

// File: tb/tb_chan_err_injector.sv
// Scoreboard bench for chan_err_injector; a second instance with CNT_W=4 exercises saturation.
module tb_chan_err_injector;

  localparam int unsigned W     = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BL_W  = 4;
`ifdef CHAN_ERR_INJ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] sym;
    logic [W-1:0] clean;
    logic [W-1:0] err;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [1:0]       cfg_mode;
  logic [4:0]       cfg_rate;
  logic [BL_W-1:0]  cfg_burst_len;
  logic [CNT_W-1:0] cfg_period;
  logic [W-1:0]     cfg_bit_mask;
  logic             valid_i;
  logic [W-1:0]     sym_i;

  logic             valid_o, burst_active_o;
  logic [W-1:0]     sym_o, clean_o, err_o;
  logic [CNT_W-1:0] sym_ct_o, err_bit_ct_o;

  logic             valid4, burst4;
  logic [W-1:0]     sym4, clean4, err4;
  logic [3:0]       sym_ct4, err_ct4;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int unsigned n_sym  = 0;
  int unsigned n_err  = 0;

  chan_err_injector dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_rate(cfg_rate),
    .cfg_burst_len(cfg_burst_len), .cfg_period(cfg_period), .cfg_bit_mask(cfg_bit_mask),
    .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o), .clean_o(clean_o),
    .err_o(err_o), .burst_active_o(burst_active_o), .sym_ct_o(sym_ct_o), .err_bit_ct_o(err_bit_ct_o)
  );

  chan_err_injector #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_rate(cfg_rate),
    .cfg_burst_len(cfg_burst_len), .cfg_period(cfg_period[3:0]), .cfg_bit_mask(cfg_bit_mask),
    .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid4), .sym_o(sym4), .clean_o(clean4),
    .err_o(err4), .burst_active_o(burst4), .sym_ct_o(sym_ct4), .err_bit_ct_o(err_ct4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Pops one expectation per output symbol.
  always @(negedge clk) begin
    if (rst && valid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: unexpected valid_o with sym=%b", sym_o);
      end else begin
        mon_e = sb.pop_front();
        if ({sym_o, clean_o, err_o} !== {mon_e.sym, mon_e.clean, mon_e.err}) begin
          errors++;
          $display("FAIL symbol: got sym=%b clean=%b err=%b, want sym=%b clean=%b err=%b",
                   sym_o, clean_o, err_o, mon_e.sym, mon_e.clean, mon_e.err);
        end
      end
    end
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned maxv);
    if (!STATS) return 0;
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic cyc(input logic v, input logic [W-1:0] s, input bit c);
    exp_t e;
    valid_i = v;
    sym_i   = s;
    if (v) begin
      e.clean = s;
      e.err   = c ? cfg_bit_mask : '0;
      e.sym   = s ^ e.err;
      sb.push_back(e);
      n_sym++;
      n_err += $countones(e.err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    cyc(1'b0, '0, 1'b0);
    rst = 1'b0;
    n_sym = 0;
    n_err = 0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({valid_o, sym_o, clean_o, err_o, burst_active_o, sym_ct_o, err_bit_ct_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want all 0",
               {valid_o, sym_o, clean_o, err_o, burst_active_o, sym_ct_o, err_bit_ct_o});
    end
    checks++;
    if ({valid4, sym4, clean4, err4, burst4, sym_ct4, err_ct4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs4: got %b, want all 0",
               {valid4, sym4, clean4, err4, burst4, sym_ct4, err_ct4});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_off();
    cfg_mode = 2'd0; cfg_rate = 5'd0; cfg_bit_mask = 2'b11;
    cfg_burst_len = 4'd3; cfg_period = 16'd5;
    for (int i = 0; i < 100; i++) cyc(1'b1, 2'b10, 1'b0);
    checks++;
    if (sym_ct_o !== CNT_W'(sat(n_sym, 65535))) begin
      errors++;
      $display("FAIL off_sym_ct: got %0d, want %0d", sym_ct_o, sat(n_sym, 65535));
    end
    checks++;
    if (err_bit_ct_o !== '0) begin
      errors++;
      $display("FAIL off_err_ct: got %0d, want 0", err_bit_ct_o);
    end
    do_reset();
    checks++;
    if ({valid_o, sym_o, clean_o, err_o, burst_active_o, sym_ct_o, err_bit_ct_o} !== '0) begin
      errors++;
      $display("FAIL off_reset: got %b, want all 0",
               {valid_o, sym_o, clean_o, err_o, burst_active_o, sym_ct_o, err_bit_ct_o});
    end
  endtask

  task automatic test_random();
    cfg_mode = 2'd1; cfg_rate = 5'd0; cfg_bit_mask = 2'b01;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, (i % 2 == 1) ? 2'b11 : 2'b00, 1'b1);
      checks++;
      if (err_bit_ct_o !== CNT_W'(sat(n_err, 65535))) begin
        errors++;
        $display("FAIL random_err_ct[%0d]: got %0d, want %0d", i, err_bit_ct_o, sat(n_err, 65535));
      end
    end
  endtask

  task automatic test_periodic();
    bit c;
    cfg_mode = 2'd3; cfg_period = 16'd5; cfg_burst_len = 4'd3; cfg_bit_mask = 2'b11;
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      c = (i >= 4 && i <= 6) || (i >= 9 && i <= 11);
      cyc(1'b1, 2'(i), c);
      checks++;
      if (burst_active_o !== (i == 4 || i == 5 || i == 9 || i == 10)) begin
        errors++;
        $display("FAIL periodic_burst_active[%0d]: got %b", i, burst_active_o);
      end
    end
  endtask

  task automatic test_burst_gaps();
    int  k;
    bit  v;
    logic exp_ba;
    k = 0;
    cfg_mode = 2'd2; cfg_rate = 5'd0; cfg_burst_len = 4'd4; cfg_bit_mask = 2'b10;
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      v = (i % 2 == 0);
      cyc(v, W'($urandom), v);
      if (v) k++;
      exp_ba = (k > 0) && ((k - 1) % 4 != 3);
      checks++;
      if (burst_active_o !== exp_ba) begin
        errors++;
        $display("FAIL gaps_burst_active[%0d]: got %b, want %b", i, burst_active_o, exp_ba);
      end
    end
    checks++;
    if (sym_ct_o !== CNT_W'(sat(n_sym, 65535))) begin
      errors++;
      $display("FAIL gaps_sym_ct: got %0d, want %0d", sym_ct_o, sat(n_sym, 65535));
    end
  endtask

  task automatic test_len_clamp();
    cfg_burst_len = 4'd0; cfg_bit_mask = 2'b01;
    for (int j = 0; j < 4; j++) begin
      cyc(1'b1, W'($urandom), 1'b1);
      checks++;
      if (burst_active_o !== 1'b0) begin
        errors++;
        $display("FAIL len0_burst_active[%0d]: got %b, want 0", j, burst_active_o);
      end
    end
    cfg_burst_len = 4'd15;
    for (int j = 0; j < 16; j++) begin
      cyc(1'b1, W'($urandom), 1'b1);
      checks++;
      if (burst_active_o !== (j % 8 != 7)) begin
        errors++;
        $display("FAIL clamp_burst_active[%0d]: got %b, want %b", j, burst_active_o, (j % 8 != 7));
      end
    end
  endtask

  task automatic test_mask_zero();
    int unsigned e0;
    cfg_burst_len = 4'd3; cfg_bit_mask = 2'b00;
    e0 = n_err;
    for (int j = 0; j < 6; j++) begin
      cyc(1'b1, W'($urandom), 1'b1);
      checks++;
      if (burst_active_o !== (j % 3 != 2)) begin
        errors++;
        $display("FAIL mask0_burst_active[%0d]: got %b, want %b", j, burst_active_o, (j % 3 != 2));
      end
    end
    checks++;
    if (err_bit_ct_o !== CNT_W'(sat(e0, 65535))) begin
      errors++;
      $display("FAIL mask0_err_ct: got %0d, want %0d", err_bit_ct_o, sat(e0, 65535));
    end
  endtask

  task automatic test_mode_switch();
    cfg_mode = 2'd3; cfg_period = 16'd5; cfg_burst_len = 4'd3; cfg_bit_mask = 2'b11;
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) cfg_mode = 2'd0;
      cyc(1'b1, 2'(i), i == 4);
      checks++;
      if (burst_active_o !== (i == 4)) begin
        errors++;
        $display("FAIL switch_burst_active[%0d]: got %b, want %b", i, burst_active_o, (i == 4));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    cfg_mode = 2'd2; cfg_rate = 5'd0; cfg_burst_len = 4'd8; cfg_bit_mask = 2'b01;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 2'b00, 1'b1);
    cyc(1'b1, 2'b11, 1'b1);
    cyc(1'b0, '0, 1'b0);
    checks++;
    if (burst_active_o !== 1'b1) begin
      errors++;
      $display("FAIL midburst_active: got %b, want 1", burst_active_o);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({burst_active_o, valid_o, err_o} !== '0) begin
      errors++;
      $display("FAIL midburst_async_reset: got %b, want 0", {burst_active_o, valid_o, err_o});
    end
    n_sym = 0;
    n_err = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_rate();
    logic [15:0] lf;
    bit v;
    bit c;
    lf = 16'hACE1;
    cfg_mode = 2'd1; cfg_rate = 5'd2; cfg_bit_mask = 2'b10;
    for (int i = 0; i < 48; i++) begin
      v = (i % 3 != 0);
      c = v && (lf[1:0] == 2'b11);
      cyc(v, W'($urandom), c);
      if (v) lf = lfsr_step(lf);
    end
    checks++;
    if (err_bit_ct_o !== CNT_W'(sat(n_err, 65535))) begin
      errors++;
      $display("FAIL rate_err_ct: got %0d, want %0d", err_bit_ct_o, sat(n_err, 65535));
    end
  endtask

  task automatic test_saturation();
    int unsigned es;
    int unsigned ee;
    do_reset();
    cfg_mode = 2'd1; cfg_rate = 5'd0; cfg_bit_mask = 2'b11;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, W'($urandom), 1'b1);
      es = sat(i + 1, 15);
      ee = sat(2 * (i + 1), 15);
      checks++;
      if ({sym_ct4, err_ct4} !== {4'(es), 4'(ee)}) begin
        errors++;
        $display("FAIL sat_counters[%0d]: got sym=%0d err=%0d, want sym=%0d err=%0d",
                 i, sym_ct4, err_ct4, es, ee);
      end
    end
    checks++;
    if ({sym_ct_o, err_bit_ct_o} !== {CNT_W'(sat(n_sym, 65535)), CNT_W'(sat(n_err, 65535))}) begin
      errors++;
      $display("FAIL wide_counters: got sym=%0d err=%0d, want sym=%0d err=%0d",
               sym_ct_o, err_bit_ct_o, sat(n_sym, 65535), sat(n_err, 65535));
    end
  endtask

  initial begin
    cfg_mode = 2'd0; cfg_rate = 5'd0; cfg_burst_len = 4'd1; cfg_period = 16'd0;
    cfg_bit_mask = 2'b00; valid_i = 1'b0; sym_i = '0;
    test_reset();
    test_off();
    test_random();
    test_periodic();
    test_burst_gaps();
    test_len_clamp();
    test_mask_zero();
    test_mode_switch();
    test_reset_mid_burst();
    test_random_rate();
    test_saturation();
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected symbols never appeared, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chan_err_injector.md
# chan_err_injector

Parametrised, synthesizable channel-impairment block placed between the convolutional encoder output and the Viterbi decoder input in the tx/rx harness. It replaces ad-hoc per-testbench corruption with one block. It flips selected bits of each valid W-bit symbol in one of four runtime modes: off, random single errors, random bursts, or periodic bursts. It outputs the clean symbol alongside the corrupted one and keeps saturating symbol and error-bit counters.

## Interface
- W, 2, symbol width (encoder output bits per step)
- MAX_BURST, 8, largest supported burst length in symbols
- CNT_W, 16, width of period counter and statistics counters
- SEED, 16'hACE1, LFSR reset value (must be non-zero)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_mode  in  2  0 OFF, 1 RANDOM, 2 BURST, 3 PERIODIC
- cfg_rate  in  5  number of low LFSR bits that must all be 1 to trigger (0..16); 0 = trigger on every valid symbol
- cfg_burst_len  in  $clog2(MAX_BURST+1)  burst length; 0 treated as 1; values above MAX_BURST clamp to MAX_BURST
- cfg_period  in  CNT_W  valid symbols between periodic triggers; 0 = never trigger
- cfg_bit_mask  in  W  bits flipped in a corrupted symbol
- valid_i  in  1  symbol strobe
- sym_i  in  W  encoder symbol
- valid_o  out  1  valid_i delayed one cycle
- sym_o  out  W  possibly corrupted symbol
- clean_o  out  W  uncorrupted symbol, aligned with sym_o
- err_o  out  W  flip mask actually applied (sym_o ^ clean_o)
- burst_active_o  out  1  FSM in BURST state
- sym_ct_o  out  CNT_W  valid symbols seen, saturating
- err_bit_ct_o  out  CNT_W  total flipped bits, saturating

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). It advances only on cycles with valid_i=1 and is held otherwise.
- Trigger on a valid symbol:
  - RANDOM and BURST: LFSR current value with bits [cfg_rate-1:0] all 1.
  - PERIODIC: period counter equals cfg_period-1.
  - OFF: never.
- Period counter counts valid symbols and wraps to 0 after cfg_period-1. It is cleared when cfg_mode is not PERIODIC.
- Effective burst length L:
  - RANDOM: L = 1.
  - BURST and PERIODIC: L = clamped cfg_burst_len.
- FSM, two states:
  - IDLE: a valid trigger corrupts the current symbol. If L>1, load remaining = L-1 and go to BURST.
  - BURST: each valid symbol is corrupted and decrements remaining. At remaining=1 with valid, return to IDLE. Triggers are ignored while in BURST.
- The symbol that started a burst is corrupted. A burst corrupts exactly L valid symbols; invalid cycles inside a burst do not consume it.
- Corrupted symbol: sym_o = sym_i ^ cfg_bit_mask and err_o = cfg_bit_mask. Otherwise sym_o = sym_i and err_o = 0. cfg_bit_mask = 0 gives err_o = 0 with the FSM unaffected.
- Counters update on valid_i only. Increments: sym_ct +1, err_bit_ct + popcount(mask applied). Both saturate at all-ones and never wrap.
- cfg_mode change while in BURST: FSM returns to IDLE next cycle. The symbol on the change cycle is processed under the new mode.

## Timing
- Latency is exactly 1 cycle, valid_i/sym_i to valid_o/sym_o/clean_o/err_o.
- Throughput is one symbol per cycle; there is no back-pressure.
- Reset values: every output 0, FSM IDLE, remaining 0, period counter 0, LFSR = SEED.
- Reset asserted mid-burst aborts the burst immediately and asynchronously. The first valid symbol after reset uses LFSR = SEED.
- Config inputs are sampled every cycle. They are quasi-static by convention, but changes must still be safe.

## Configuration
- CHAN_ERR_INJ_STATS_EN
  - Defined: sym_ct_o and err_bit_ct_o counters are built as above.
  - Undefined: no counter registers exist and both outputs are tied to 0.
  - Injection behaviour is identical either way.

## Structure
- Shared package chan_err_pkg:
  - mode enum (ERR_OFF, ERR_RANDOM, ERR_BURST, ERR_PERIODIC)
  - LFSR_W = 16
  - LFSR_POLY = 16'hB400
  - FSM state typedef
- Sub-module err_lfsr: enable-gated Galois LFSR with SEED parameter and async active-low reset. Everything else lives in the top module.

## Test plan
- OFF mode, 100 valid symbols of 2'b10, then reset → sym_o = clean_o = 2'b10 and err_o = 0 throughout; sym_ct_o = 100, err_bit_ct_o = 0; after reset all outputs are 0.
- RANDOM, cfg_rate = 0, mask 2'b01, sym_i alternating 00/11 → every output symbol has bit 0 flipped (01, 10, …); err_bit_ct_o increments by 1 per valid symbol.
- PERIODIC, cfg_period = 5, burst_len = 3, mask 2'b11, valid on every cycle → corrupted symbols at indices 4–6 and 9–11 (0-based), with burst_active_o high during each burst.
- BURST, cfg_rate = 0, burst_len = 4, valid_i low on alternate cycles → exactly 4 valid symbols are corrupted per burst and invalid cycles are not counted.
- PERIODIC, burst_len = 3, mode switched to OFF on the second symbol of a burst → that symbol and all later symbols are clean; FSM returns to IDLE.
- Statistics saturation, with CNT_W = 4 and CHAN_ERR_INJ_STATS_EN defined, 20 valid symbols at rate 0 with mask 2'b11 → both counters hold at 4'hF. With the macro undefined, both counters read 0.
